stream_arbiter_qos_pkt: RTL and testbench



---
 rtl/stream_arb_pkg.sv | 23 ++
 rtl/stream_skid_slice.sv | 66 ++++++
 rtl/stream_arbiter_qos_pkt.sv | 189 ++++++++++++++++++
 tb/tb_stream_arbiter_qos_pkt.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared types for the packet QoS stream arbiter.
// FSM state enum, default beat struct, age counter width.
package stream_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int AGE_CNT_W  = 8;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_QOS_W  = 4;
    localparam int DEF_ID_W   = 1;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_QOS_W-1:0]  qos;
        logic [DEF_ID_W-1:0]   id;
        logic                  last;
    } beat_t;

endpackage

// File: rtl/stream_skid_slice.sv
// stream_skid_slice: generic 2-entry valid/ready register slice.
// Ports: in_beat/in_valid/in_ready (upstream), out_beat/out_valid/out_ready
// (downstream, driven straight from registers); clk_i, async active-low rst_n.
module stream_skid_slice
    import stream_arb_pkg::*;
#(
    parameter type beat_t = stream_arb_pkg::beat_t
) (
    input  logic  clk_i,
    input  logic  rst_n,
    input  beat_t in_beat,
    input  logic  in_valid,
    output logic  in_ready,
    output beat_t out_beat,
    output logic  out_valid,
    input  logic  out_ready
);

    logic [1:0] count_q;
    beat_t      head_q;
    beat_t      skid_q;
    logic       push;
    logic       pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_beat  = head_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // head_q is always the oldest beat; skid_q only holds the second one.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= in_beat;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= in_beat;
                    end else if (push) begin
                        skid_q  <= in_beat;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_q  <= skid_q;
                        count_q <= 2'd1;
                    end
                end
                default: count_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/stream_arbiter_qos_pkt.sv
// stream_arbiter_qos_pkt: packet-locked QoS arbiter, RR tie-break, skid output.
// Ports: s_* per-stream inputs/ready, m_* registered output stream, clk_i, rst_n.
// Optional aging build: define STREAM_ARB_AGING_EN.
module stream_arbiter_qos_pkt
    import stream_arb_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS__WIDTH = 4,
    parameter int STREAM_COUNT = 2,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
    parameter int AGE_LIMIT    = 8
) (
    input  logic                                     clk_i,
    input  logic                                     rst_n,
    input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_i,
    input  logic [STREAM_COUNT-1:0]                  s_last_i,
    input  logic [STREAM_COUNT-1:0]                  s_valid_i,
    output logic [STREAM_COUNT-1:0]                  s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                  m_data_o,
    output logic [T_QOS__WIDTH-1:0]                  m_qos_o,
    output logic [T_ID___WIDTH-1:0]                  m_id_o,
    output logic                                     m_last_o,
    output logic                                     m_valid_o,
    input  logic                                     m_ready_i
);

    if (STREAM_COUNT < 2 || AGE_LIMIT < 1 || AGE_LIMIT > 255) begin : g_param_check
        $error("stream_arbiter_qos_pkt: parameter out of range");
    end

    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] data;
        logic [T_QOS__WIDTH-1:0] qos;
        logic [T_ID___WIDTH-1:0] id;
        logic                    last;
    } slot_t;

    localparam logic [T_ID___WIDTH-1:0] LAST_ID = T_ID___WIDTH'(STREAM_COUNT - 1);

    arb_state_e              state_q;
    arb_state_e              state_d;
    logic [T_ID___WIDTH-1:0] grant_q;
    logic [T_ID___WIDTH-1:0] grant_d;
    logic [T_ID___WIDTH-1:0] rr_ptr_q;
    logic [T_ID___WIDTH-1:0] rr_ptr_d;
    logic [T_ID___WIDTH-1:0] win_id;
    logic [T_ID___WIDTH-1:0] cand;
    logic [STREAM_COUNT-1:0] aged;
    logic [T_QOS__WIDTH-1:0] best_qos;
    logic                    best_found;
    logic                    best_aged;
    int                      sum;
    logic                    any_valid;
    logic                    decide;
    logic                    can_accept;
    logic                    in_valid;
    logic                    xfer;
    slot_t                   beat_in;
    slot_t                   beat_out;

    assign any_valid = |s_valid_i;
    assign in_valid  = (state_q == BUSY) && s_valid_i[grant_q];
    assign xfer      = in_valid && can_accept;

    // Scan from rr_ptr and keep a candidate only if it is strictly better,
    // so equal candidates resolve to the first one met after rr_ptr.
    always_comb begin
        win_id     = rr_ptr_q;
        cand       = rr_ptr_q;
        best_qos   = '0;
        best_found = 1'b0;
        best_aged  = 1'b0;
        sum        = 0;
        for (int k = 0; k < STREAM_COUNT; k++) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= STREAM_COUNT) begin
                sum = sum - STREAM_COUNT;
            end
            cand = T_ID___WIDTH'(sum);
            if (s_valid_i[cand]) begin
                if (!best_found ||
                    (aged[cand] && !best_aged) ||
                    ((aged[cand] == best_aged) && (s_qos_i[cand] > best_qos))) begin
                    best_found = 1'b1;
                    best_aged  = aged[cand];
                    best_qos   = s_qos_i[cand];
                    win_id     = cand;
                end
            end
        end
    end

`ifdef STREAM_ARB_AGING_EN
    logic [AGE_CNT_W-1:0] age_q [STREAM_COUNT];

    // Counters saturate at all-ones, so a stream stays aged even if it
    // keeps losing to other aged streams.
    always_comb begin
        aged = '0;
        for (int i = 0; i < STREAM_COUNT; i++) begin
            aged[i] = (age_q[i] >= AGE_CNT_W'(AGE_LIMIT));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STREAM_COUNT; i++) begin
                age_q[i] <= '0;
            end
        end else if (decide) begin
            for (int i = 0; i < STREAM_COUNT; i++) begin
                if (T_ID___WIDTH'(i) == win_id) begin
                    age_q[i] <= '0;
                end else if (s_valid_i[i] && (age_q[i] != '1)) begin
                    age_q[i] <= age_q[i] + AGE_CNT_W'(1);
                end
            end
        end
    end
`else
    assign aged = '0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        s_ready_o = '0;
        decide    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    decide   = 1'b1;
                    grant_d  = win_id;
                    rr_ptr_d = (win_id == LAST_ID) ? '0
                                                   : win_id + T_ID___WIDTH'(1);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                s_ready_o[grant_q] = can_accept;
                if (xfer && s_last_i[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        beat_in      = '0;
        beat_in.data = s_data_i[grant_q];
        beat_in.qos  = s_qos_i[grant_q];
        beat_in.id   = grant_q;
        beat_in.last = s_last_i[grant_q];
    end

    stream_skid_slice #(
        .beat_t(slot_t)
    ) u_slice (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .in_beat  (beat_in),
        .in_valid (in_valid),
        .in_ready (can_accept),
        .out_beat (beat_out),
        .out_valid(m_valid_o),
        .out_ready(m_ready_i)
    );

    assign m_data_o = beat_out.data;
    assign m_qos_o  = beat_out.qos;
    assign m_id_o   = beat_out.id;
    assign m_last_o = beat_out.last;

endmodule

// File: tb/tb_stream_arbiter_qos_pkt.sv
// tb_stream_arbiter_qos_pkt: directed scoreboard bench for the QoS arbiter.
// Per-stream beat queues feed a driver; a monitor pops expected beats.
`timescale 1ns/1ps
module tb_stream_arbiter_qos_pkt;

    localparam int DW = 8;
    localparam int QW = 4;
    localparam int SC = 2;
    localparam int IW = 1;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] qos;
        logic       id;
        logic       last;
    } tb_beat_t;

    logic                   clk_i = 1'b0;
    logic                   rst_n;
    logic [SC-1:0][DW-1:0]  s_data_i;
    logic [SC-1:0][QW-1:0]  s_qos_i;
    logic [SC-1:0]          s_last_i;
    logic [SC-1:0]          s_valid_i;
    logic [SC-1:0]          s_ready_o;
    logic [DW-1:0]          m_data_o;
    logic [QW-1:0]          m_qos_o;
    logic [IW-1:0]          m_id_o;
    logic                   m_last_o;
    logic                   m_valid_o;
    logic                   m_ready_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    tb_beat_t tx0[$];
    tb_beat_t tx1[$];
    tb_beat_t exp_q[$];
    int       hs_cyc[$];

    stream_arbiter_qos_pkt #(
        .T_DATA_WIDTH(DW),
        .T_QOS__WIDTH(QW),
        .STREAM_COUNT(SC),
        .AGE_LIMIT   (3)
    ) dut (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .s_data_i (s_data_i),
        .s_qos_i  (s_qos_i),
        .s_last_i (s_last_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .m_data_o (m_data_o),
        .m_qos_o  (m_qos_o),
        .m_id_o   (m_id_o),
        .m_last_o (m_last_o),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_tx(input int s, input logic [7:0] d,
                           input logic [3:0] q, input logic l);
        tb_beat_t b;
        b.data = d;
        b.qos  = q;
        b.id   = s[0];
        b.last = l;
        if (s == 0) tx0.push_back(b);
        else        tx1.push_back(b);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [3:0] q,
                            input logic i, input logic l);
        tb_beat_t b;
        b.data = d;
        b.qos  = q;
        b.id   = i;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic do_reset();
        tx0.delete();
        tx1.delete();
        m_ready_i = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst_n = 1'b1;
        @(posedge clk_i);
        #2;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || tx0.size() > 0 || tx1.size() > 0)
               && n < 300) begin
            @(posedge clk_i);
            n++;
        end
        check({name, " drained"}, 32'(n < 300), 32'd1);
        repeat (3) @(posedge clk_i);
        #2;
    endtask

    // Driver: handshake sampled mid-cycle, queue head presented after the edge.
    initial begin : driver
        logic [SC-1:0] hs;
        s_valid_i = '0;
        s_data_i  = '0;
        s_qos_i   = '0;
        s_last_i  = '0;
        forever begin
            @(negedge clk_i);
            hs = s_valid_i & s_ready_o;
            @(posedge clk_i);
            #1;
            if (hs[0] && tx0.size() > 0) tx0.delete(0);
            if (hs[1] && tx1.size() > 0) tx1.delete(0);
            if (tx0.size() > 0) begin
                s_valid_i[0] = 1'b1;
                s_data_i[0]  = tx0[0].data;
                s_qos_i[0]   = tx0[0].qos;
                s_last_i[0]  = tx0[0].last;
            end else begin
                s_valid_i[0] = 1'b0;
            end
            if (tx1.size() > 0) begin
                s_valid_i[1] = 1'b1;
                s_data_i[1]  = tx1[0].data;
                s_qos_i[1]   = tx1[0].qos;
                s_last_i[1]  = tx1[0].last;
            end else begin
                s_valid_i[1] = 1'b0;
            end
        end
    end

    initial begin : monitor
        tb_beat_t cur;
        tb_beat_t prev;
        tb_beat_t e;
        logic     stall_prev;
        stall_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk_i);
            cur = {m_data_o, m_qos_o, m_id_o, m_last_o};
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall hold", {18'd0, m_valid_o, cur},
                          {18'd0, 1'b1, prev});
                end
                if (m_valid_o && m_ready_i) begin
                    hs_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL beat: got unexpected %0h required none",
                                 cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 32'(cur), 32'(e));
                    end
                end
                stall_prev = m_valid_o && !m_ready_i;
                prev = cur;
            end
        end
    end

    initial begin : stim
        int       k;
        int       base;
        tb_beat_t t;

        m_ready_i = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset m_*", {m_valid_o, m_last_o, m_id_o, m_qos_o, m_data_o},
              32'd0);
        check("reset s_ready", 32'(s_ready_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #2 rst_n = 1'b1;
        @(posedge clk_i);
        #2;

        // 1: qos priority and first-beat latency
        push_tx(0, 8'hA0, 4'd2, 1'b0);
        push_tx(0, 8'hA1, 4'd2, 1'b0);
        push_tx(0, 8'hA2, 4'd2, 1'b1);
        push_tx(1, 8'hB0, 4'd5, 1'b0);
        push_tx(1, 8'hB1, 4'd5, 1'b1);
        push_exp(8'hB0, 4'd5, 1'b1, 1'b0);
        push_exp(8'hB1, 4'd5, 1'b1, 1'b1);
        push_exp(8'hA0, 4'd2, 1'b0, 1'b0);
        push_exp(8'hA1, 4'd2, 1'b0, 1'b0);
        push_exp(8'hA2, 4'd2, 1'b0, 1'b1);
        @(posedge clk_i);
        k = 0;
        while (k < 10) begin
            @(negedge clk_i);
            if (m_valid_o) break;
            k++;
        end
        check("t1 first valid cycle", 32'(k), 32'd2);
        drain("t1");

        // 2: round-robin on equal qos, one bubble per packet
        do_reset();
        push_tx(0, 8'h20, 4'd3, 1'b1);
        push_tx(0, 8'h22, 4'd3, 1'b1);
        push_tx(1, 8'h21, 4'd3, 1'b1);
        push_tx(1, 8'h23, 4'd3, 1'b1);
        push_exp(8'h20, 4'd3, 1'b0, 1'b1);
        push_exp(8'h21, 4'd3, 1'b1, 1'b1);
        push_exp(8'h22, 4'd3, 1'b0, 1'b1);
        push_exp(8'h23, 4'd3, 1'b1, 1'b1);
        base = hs_cyc.size();
        drain("t2");
        check("t2 beat count", 32'(hs_cyc.size() - base), 32'd4);
        if (hs_cyc.size() - base == 4) begin
            for (int i = 0; i < 3; i++) begin
                check("t2 spacing", 32'(hs_cyc[base+i+1] - hs_cyc[base+i]),
                      32'd2);
            end
        end

        // 3: backpressure, m_ready low for cycles 3..6
        do_reset();
        push_tx(0, 8'h30, 4'd7, 1'b0);
        push_tx(0, 8'h31, 4'd7, 1'b0);
        push_tx(0, 8'h32, 4'd7, 1'b0);
        push_tx(0, 8'h33, 4'd7, 1'b1);
        push_exp(8'h30, 4'd7, 1'b0, 1'b0);
        push_exp(8'h31, 4'd7, 1'b0, 1'b0);
        push_exp(8'h32, 4'd7, 1'b0, 1'b0);
        push_exp(8'h33, 4'd7, 1'b0, 1'b1);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_i);
            #1;
            m_ready_i = !(c >= 3 && c <= 6);
            @(negedge clk_i);
            if (c == 3) check("t3 ready c3", 32'(s_ready_o[0]), 32'd1);
            if (c == 4) check("t3 ready c4", 32'(s_ready_o[0]), 32'd0);
            if (c == 6) check("t3 ready c6", 32'(s_ready_o[0]), 32'd0);
            if (c == 8) check("t3 ready c8", 32'(s_ready_o[0]), 32'd1);
            if (c == 5) check("t3 held data", {m_valid_o, m_data_o},
                              {1'b1, 8'h31});
        end
        m_ready_i = 1'b1;
        drain("t3");

        // 4: packet lock against mid-packet qos raise
        do_reset();
        push_tx(0, 8'h40, 4'd1, 1'b0);
        push_tx(0, 8'h41, 4'd1, 1'b0);
        push_tx(0, 8'h42, 4'd1, 1'b1);
        push_tx(1, 8'h48, 4'd1, 1'b0);
        push_tx(1, 8'h49, 4'd1, 1'b1);
        push_exp(8'h40, 4'd1, 1'b0, 1'b0);
        push_exp(8'h41, 4'd1, 1'b0, 1'b0);
        push_exp(8'h42, 4'd1, 1'b0, 1'b1);
        push_exp(8'h48, 4'd15, 1'b1, 1'b0);
        push_exp(8'h49, 4'd15, 1'b1, 1'b1);
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        for (int i = 0; i < 2; i++) begin
            t = tx1[i];
            t.qos = 4'd15;
            tx1[i] = t;
        end
        drain("t4");

        // 5: reset mid-packet, RR pointer restarts at 0
        do_reset();
        push_tx(0, 8'h50, 4'd1, 1'b0);
        push_tx(0, 8'h51, 4'd1, 1'b0);
        push_tx(0, 8'h52, 4'd1, 1'b0);
        push_tx(0, 8'h53, 4'd1, 1'b1);
        push_exp(8'h50, 4'd1, 1'b0, 1'b0);
        @(posedge clk_i);
        repeat (3) @(posedge clk_i);
        #2 rst_n = 1'b0;
        #1;
        check("t5 reset m_*", {m_valid_o, m_last_o, m_id_o, m_qos_o, m_data_o},
              32'd0);
        check("t5 reset s_ready", 32'(s_ready_o), 32'd0);
        check("t5 scoreboard", 32'(exp_q.size()), 32'd0);
        tx0.delete();
        tx1.delete();
        repeat (2) @(posedge clk_i);
        #2 rst_n = 1'b1;
        @(negedge clk_i);
        check("t5 slice empty", 32'(m_valid_o), 32'd0);
        @(posedge clk_i);
        #2;
        push_tx(0, 8'h5A, 4'd1, 1'b1);
        push_tx(1, 8'h5B, 4'd1, 1'b1);
        push_exp(8'h5A, 4'd1, 1'b0, 1'b1);
        push_exp(8'h5B, 4'd1, 1'b1, 1'b1);
        drain("t5");

        // 6: starvation aging with AGE_LIMIT=3
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_tx(1, 8'h60 + 8'(i), 4'd15, 1'b1);
        end
        push_tx(0, 8'h7A, 4'd0, 1'b1);
`ifdef STREAM_ARB_AGING_EN
        for (int i = 0; i < 3; i++) push_exp(8'h60 + 8'(i), 4'd15, 1'b1, 1'b1);
        push_exp(8'h7A, 4'd0, 1'b0, 1'b1);
        for (int i = 3; i < 6; i++) push_exp(8'h60 + 8'(i), 4'd15, 1'b1, 1'b1);
`else
        for (int i = 0; i < 6; i++) push_exp(8'h60 + 8'(i), 4'd15, 1'b1, 1'b1);
        push_exp(8'h7A, 4'd0, 1'b0, 1'b1);
`endif
        drain("t6");

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
